servo_motion_ctrl: RTL and testbench

- Rate-limited motion sequencer for a bank of hobby-servo PWM channels on the hexapod.
- Holds a target position and a per-channel slew rate for each servo. Once per PWM frame it steps each channel's current position toward its target.
- Drives a shared 16-bit position bus plus one-hot update strobes into the per-channel PWM generators (position[15:0], update inputs; 32768 = centre).
- Lets the gait logic command large moves without mechanically slamming the legs.

---
 rtl/servo_motion_ctrl.sv | 163 ++++++++++++++++
 tb/tb_servo_motion_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servo_motion_ctrl
// Purpose  : Rate-limited motion sequencer for a bank of hobby-servo PWM
//            channels. Each channel holds a target position and a slew rate.
//            On every PWM frame tick the channels are scanned in order. Each
//            channel's current position moves toward its target by at most
//            its rate. The result is broadcast on a shared position bus and
//            qualified by a one-hot update strobe.
// Ports    :
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   frame_tick  in   one-cycle pulse at PWM frame wrap
//   cmd_valid   in   command request
//   cmd_ready   out  command accepted when valid & ready at posedge (IDLE only)
//   cmd_idx     in   target channel (out-of-range indices are accepted, dropped)
//   cmd_target  in   new target position
//   cmd_rate    in   new slew rate, 0 = jump in one frame
//   position    out  shared position bus to PWM channels
//   update      out  one-hot load strobe qualifying position
//   in_motion   out  bit i high while current[i] != target[i]
//   frame_done  out  one-cycle pulse after the last channel is emitted
//   overrun     out  sticky: frame_tick arrived while scanning
// Revision : 1.0 - initial release
// ============================================================================
module servo_motion_ctrl #(
  parameter int          NUM_SERVOS   = 18,
  parameter int          IDX_W        = 5,
  parameter logic [15:0] CENTER       = 16'd32768,
  parameter logic [15:0] DEFAULT_RATE = 16'd256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IDX_W-1:0]      cmd_idx,
  input  logic [15:0]           cmd_target,
  input  logic [15:0]           cmd_rate,
  output logic [15:0]           position,
  output logic [NUM_SERVOS-1:0] update,
  output logic [NUM_SERVOS-1:0] in_motion,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_SERVOS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [15:0]           r_cur  [NUM_SERVOS];
  logic [15:0]           r_tgt  [NUM_SERVOS];
  logic [15:0]           r_rate [NUM_SERVOS];
  logic [15:0]           r_position;
  logic [NUM_SERVOS-1:0] r_update;
  logic                  r_frame_done;
  logic                  r_overrun;

  logic [15:0] w_cur;
  logic [15:0] w_tgt;
  logic [15:0] w_rate;
  logic        w_up;
  logic [16:0] w_dist;
  logic [15:0] w_next;
  logic        w_cmd_write;

  // Step arithmetic for the channel under scan. The distance is computed
  // 17 bits wide. A full step is taken only when the distance strictly
  // exceeds the rate, so add/subtract can never overshoot or wrap.
  always_comb begin
    w_cur  = r_cur[r_idx];
    w_tgt  = r_tgt[r_idx];
    w_rate = r_rate[r_idx];
    w_up   = (w_tgt > w_cur);
    w_dist = w_up ? ({1'b0, w_tgt} - {1'b0, w_cur})
                  : ({1'b0, w_cur} - {1'b0, w_tgt});
    if ((w_rate == 16'd0) || (w_dist <= {1'b0, w_rate})) begin
      w_next = w_tgt;
    end else if (w_up) begin
      w_next = w_cur + w_rate;
    end else begin
      w_next = w_cur - w_rate;
    end
  end

  // Out-of-range indices still complete the handshake but write nothing.
  assign w_cmd_write = cmd_valid && (r_state == S_IDLE) &&
                       (int'(cmd_idx) < NUM_SERVOS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_position   <= CENTER;
      r_update     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        r_cur[i]  <= CENTER;
        r_tgt[i]  <= CENTER;
        r_rate[i] <= DEFAULT_RATE;
      end
    end else begin
      r_update     <= '0;
      r_frame_done <= 1'b0;

      if (frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      // The command write and a same-edge frame_tick coexist. Channel
      // cmd_idx is scanned on a later edge, so the scan sees the new values.
      if (w_cmd_write) begin
        r_tgt[cmd_idx]  <= cmd_target;
        r_rate[cmd_idx] <= cmd_rate;
      end

      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          r_cur[r_idx]    <= w_next;
          r_position      <= w_next;
          r_update[r_idx] <= 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_motion
      assign in_motion[g] = (r_cur[g] != r_tgt[g]);
    end
  endgenerate

  assign cmd_ready  = (r_state == S_IDLE);
  assign position   = r_position;
  assign update     = r_update;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_servo_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_motion_ctrl
// Purpose  : Directed self-checking bench for servo_motion_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_motion_ctrl;

  localparam int N = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [4:0]    cmd_idx = '0;
  logic [15:0]   cmd_target = '0;
  logic [15:0]   cmd_rate = '0;
  logic [15:0]   position;
  logic [N-1:0]  update;
  logic [N-1:0]  in_motion;
  logic          frame_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Per-frame capture, filled by do_frame.
  int          cap_cycle [N];
  logic [15:0] cap_pos   [N];
  int          done_cycle;
  int          done_count;
  int          strobe_count;
  int          bad_strobes;

  servo_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_idx    (cmd_idx),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .position   (position),
    .update     (update),
    .in_motion  (in_motion),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] idx, input logic [15:0] tgt,
                          input logic [15:0] rate);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_wait: cmd_ready stayed 0, required 1");
    end
    cmd_valid  = 1'b1;
    cmd_idx    = idx;
    cmd_target = tgt;
    cmd_rate   = rate;
    step();
    cmd_valid = 1'b0;
  endtask

  // Pulses frame_tick (optionally with a same-edge command) and records
  // 30 cycles of bus activity. Cycle c is sampled just after edge E(c).
  task automatic do_frame(input bit with_cmd, input logic [4:0] idx,
                          input logic [15:0] tgt, input logic [15:0] rate,
                          input int extra_tick_at);
    for (int i = 0; i < N; i++) begin
      cap_cycle[i] = -1;
      cap_pos[i]   = '0;
    end
    done_cycle   = -1;
    done_count   = 0;
    strobe_count = 0;
    bad_strobes  = 0;
    frame_tick = 1'b1;
    if (with_cmd) begin
      cmd_valid  = 1'b1;
      cmd_idx    = idx;
      cmd_target = tgt;
      cmd_rate   = rate;
    end
    step();
    frame_tick = 1'b0;
    cmd_valid  = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == extra_tick_at) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (update != '0) begin
        strobe_count++;
        if ($onehot(update)) begin
          for (int i = 0; i < N; i++) begin
            if (update[i]) begin
              cap_cycle[i] = c;
              cap_pos[i]   = position;
            end
          end
        end else begin
          bad_strobes++;
        end
      end
      if (frame_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (position !== 16'd32768) begin
      errors++; $display("FAIL reset_position: got %0d required 32768", position);
    end
    checks++;
    if (update !== '0) begin
      errors++; $display("FAIL reset_update: got %h required 0", update);
    end
    checks++;
    if (frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: frame_done %b overrun %b required 0 0", frame_done, overrun);
    end
    checks++;
    if (in_motion !== '0) begin
      errors++; $display("FAIL reset_in_motion: got %h required 0", in_motion);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_center_frame();
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_cycle[i] != i + 1 || cap_pos[i] !== 16'd32768) begin
        errors++;
        $display("FAIL center_ch%0d: cycle %0d pos %0d required cycle %0d pos 32768",
                 i, cap_cycle[i], cap_pos[i], i + 1);
      end
    end
    checks++;
    if (done_cycle != 19 || done_count != 1) begin
      errors++; $display("FAIL center_frame_done: cycle %0d count %0d required 19 1", done_cycle, done_count);
    end
    checks++;
    if (strobe_count != 18 || bad_strobes != 0) begin
      errors++; $display("FAIL center_strobes: count %0d bad %0d required 18 0", strobe_count, bad_strobes);
    end
    checks++;
    if (in_motion !== '0) begin
      errors++; $display("FAIL center_in_motion: got %h required 0", in_motion);
    end
  endtask

  task automatic test_slew();
    logic [15:0] exp_pos [3];
    logic        exp_mov [3];
    exp_pos[0] = 16'd32868; exp_mov[0] = 1'b1;
    exp_pos[1] = 16'd32968; exp_mov[1] = 1'b1;
    exp_pos[2] = 16'd33000; exp_mov[2] = 1'b0;
    send_cmd(5'd3, 16'd33000, 16'd100);
    checks++;
    if (in_motion[3] !== 1'b1) begin
      errors++; $display("FAIL slew_motion_start: got %b required 1", in_motion[3]);
    end
    for (int f = 0; f < 3; f++) begin
      do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
      checks++;
      if (cap_pos[3] !== exp_pos[f] || cap_cycle[3] != 4) begin
        errors++; $display("FAIL slew_frame%0d: pos %0d cycle %0d required %0d 4",
                           f, cap_pos[3], cap_cycle[3], exp_pos[f]);
      end
      checks++;
      if (in_motion[3] !== exp_mov[f]) begin
        errors++; $display("FAIL slew_motion%0d: got %b required %b", f, in_motion[3], exp_mov[f]);
      end
    end
    checks++;
    if (cap_pos[4] !== 16'd32768) begin
      errors++; $display("FAIL slew_neighbour: ch4 pos %0d required 32768", cap_pos[4]);
    end
  endtask

  task automatic test_jump();
    send_cmd(5'd5, 16'd50, 16'd0);
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
    checks++;
    if (cap_pos[5] !== 16'd50) begin
      errors++; $display("FAIL jump_pos: got %0d required 50", cap_pos[5]);
    end
    checks++;
    if (in_motion[5] !== 1'b0) begin
      errors++; $display("FAIL jump_motion: got %b required 0", in_motion[5]);
    end
  endtask

  task automatic test_clamp();
    send_cmd(5'd6, 16'd65535, 16'd40000);
    send_cmd(5'd7, 16'd100, 16'd0);
    send_cmd(5'd8, 16'd0, 16'd40000);
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
    checks++;
    if (cap_pos[6] !== 16'd65535) begin
      errors++; $display("FAIL clamp_high: got %0d required 65535", cap_pos[6]);
    end
    checks++;
    if (cap_pos[8] !== 16'd0) begin
      errors++; $display("FAIL clamp_low_big_rate: got %0d required 0", cap_pos[8]);
    end
    send_cmd(5'd7, 16'd0, 16'd300);
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
    checks++;
    if (cap_pos[7] !== 16'd0) begin
      errors++; $display("FAIL clamp_low: got %0d required 0", cap_pos[7]);
    end
    checks++;
    if (in_motion !== '0) begin
      errors++; $display("FAIL clamp_in_motion: got %h required 0", in_motion);
    end
  endtask

  task automatic test_dropped_cmd();
    send_cmd(5'd31, 16'd1234, 16'd1);
    checks++;
    if (in_motion !== '0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL dropped_cmd: in_motion %h ready %b required 0 1", in_motion, cmd_ready);
    end
  endtask

  task automatic test_same_edge();
    do_frame(1'b1, 5'd10, 16'd1000, 16'd0, -1);
    checks++;
    if (cap_pos[10] !== 16'd1000) begin
      errors++; $display("FAIL same_edge_pos: got %0d required 1000", cap_pos[10]);
    end
  endtask

  task automatic test_cmd_stall();
    int low_cycles;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    cmd_valid  = 1'b1;
    cmd_idx    = 5'd9;
    cmd_target = 16'd40000;
    cmd_rate   = 16'd0;
    low_cycles = 0;
    while (!cmd_ready && low_cycles < 40) begin
      low_cycles++;
      step();
    end
    checks++;
    if (in_motion[9] !== 1'b0) begin
      errors++; $display("FAIL stall_early_write: in_motion[9] %b required 0", in_motion[9]);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (low_cycles != 19) begin
      errors++; $display("FAIL stall_ready_low: got %0d cycles required 19", low_cycles);
    end
    checks++;
    if (in_motion[9] !== 1'b1) begin
      errors++; $display("FAIL stall_accept: in_motion[9] %b required 1", in_motion[9]);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL stall_overrun: got %b required 0", overrun);
    end
  endtask

  task automatic test_overrun_reset();
    int waited;
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, 5);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b required 1", overrun);
    end
    checks++;
    if (strobe_count != 18 || done_count != 1 || cap_cycle[17] != 18) begin
      errors++; $display("FAIL overrun_scan: strobes %0d done %0d last %0d required 18 1 18",
                         strobe_count, done_count, cap_cycle[17]);
    end
    checks++;
    if (cap_pos[9] !== 16'd40000) begin
      errors++; $display("FAIL overrun_ch9: got %0d required 40000", cap_pos[9]);
    end
    // Reset in the middle of a scan, right when update[7] is on the bus.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    waited = 0;
    while (update[7] !== 1'b1 && waited < 30) begin
      step();
      waited++;
    end
    checks++;
    if (update[7] !== 1'b1) begin
      errors++; $display("FAIL rst_wait: update[7] never seen, required 1");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (update !== '0 || position !== 16'd32768 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid_scan: update %h pos %0d overrun %b required 0 32768 0",
                         update, position, overrun);
    end
    checks++;
    if (cmd_ready !== 1'b1 || in_motion !== '0) begin
      errors++; $display("FAIL rst_state: ready %b in_motion %h required 1 0", cmd_ready, in_motion);
    end
    step();
    do_frame(1'b0, 5'd0, 16'd0, 16'd0, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_pos[i] !== 16'd32768 || cap_cycle[i] != i + 1) begin
        errors++; $display("FAIL post_rst_ch%0d: pos %0d cycle %0d required 32768 %0d",
                           i, cap_pos[i], cap_cycle[i], i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_center_frame();
    test_slew();
    test_jump();
    test_clamp();
    test_dropped_cmd();
    test_same_edge();
    test_cmd_stall();
    test_overrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
